// File: rtl/fu_wb_arbiter_pkg.sv
// Shared FU result / completion types and default sizing for the write-back arbiter.
package fu_wb_arbiter_pkg;
  localparam int NB_FU         = 5;
  localparam int NR_WB_PORTS   = 2;
  localparam int TRANS_ID_BITS = 8;
  localparam int XLEN          = 32;

  typedef struct packed {
    logic [TRANS_ID_BITS-1:0] id;
    logic [XLEN-1:0]          data;
    logic [4:0]               rd;
  } fu_output_t;

  typedef struct packed {
    logic [TRANS_ID_BITS-1:0] id;
    logic                     valid;
  } completion_port_t;

  typedef logic [$clog2(NB_FU)-1:0] wb_src_idx_t;

  // Single-step modulo for indices known to be below 2*n.
  function automatic int rr_wrap(input int idx, input int n);
    return (idx >= n) ? idx - n : idx;
  endfunction
endpackage

// File: rtl/fu_wb_fifo.sv
// Per-source result queue: BUF_DEPTH entries, full/empty from registered occupancy, head read combinationally.
module fu_wb_fifo #(
  parameter int  BUF_DEPTH = 2,
  parameter type T         = logic
) (
  input  logic clk,
  input  logic rstn,
  input  logic i_push,
  input  T     i_dat,
  input  logic i_pop,
  output logic o_full,
  output logic o_empty,
  output T     o_head
);
  localparam int PTR_W = $clog2(BUF_DEPTH);

  T                 r_mem [BUF_DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [PTR_W:0]   r_cnt;

  assign o_full  = (r_cnt == (PTR_W+1)'(BUF_DEPTH));
  assign o_empty = (r_cnt == '0);
  assign o_head  = r_mem[r_rptr];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + 1'b1;
      if (i_pop)  r_rptr <= r_rptr + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wptr] <= i_dat;
  end
endmodule

// File: rtl/fu_wb_arbiter.sv
// Round-robin merge of NR_SRC FU result queues onto NR_PORTS registered write-back + completion ports.
// Define FU_WB_BYPASS_EN to let a valid input with an empty queue compete directly (1-cycle latency).
module fu_wb_arbiter
  import fu_wb_arbiter_pkg::*;
#(
  parameter int NR_SRC    = NB_FU,
  parameter int NR_PORTS  = NR_WB_PORTS,
  parameter int BUF_DEPTH = 2
) (
  input  logic                clk,
  input  logic                rstn,
  input  fu_output_t          src_i        [NR_SRC],
  input  logic [NR_SRC-1:0]   src_valid_i,
  output logic [NR_SRC-1:0]   src_ready_o,
  output fu_output_t          wb_o         [NR_PORTS],
  output logic [NR_PORTS-1:0] wb_valid_o,
  output completion_port_t    completion_o [NR_PORTS]
);
  localparam int IDX_W = (NR_SRC > 1) ? $clog2(NR_SRC) : 1;

  logic [NR_SRC-1:0]   w_full;
  logic [NR_SRC-1:0]   w_empty;
  logic [NR_SRC-1:0]   w_byp;
  logic [NR_SRC-1:0]   w_cand;
  logic [NR_SRC-1:0]   w_grant;
  logic [NR_SRC-1:0]   w_push;
  logic [NR_SRC-1:0]   w_pop;
  fu_output_t          w_head     [NR_SRC];
  fu_output_t          w_port_dat [NR_PORTS];
  logic [NR_PORTS-1:0] w_port_vld;
  logic [IDX_W-1:0]    w_rr_nxt;
  logic [IDX_W-1:0]    w_sidx;
  int                  w_nport;

  logic [IDX_W-1:0]    r_rr;
  fu_output_t          r_wb       [NR_PORTS];
  logic [NR_PORTS-1:0] r_wb_vld;

`ifdef FU_WB_BYPASS_EN
  assign w_byp = w_empty & src_valid_i;
`else
  assign w_byp = '0;
`endif

  // Ready comes from registered occupancy only; a same-cycle pop never frees a full queue.
  assign src_ready_o = ~w_full;
  assign w_cand      = ~w_empty | w_byp;
  assign w_pop       = w_grant & ~w_empty;
  assign w_push      = src_valid_i & ~w_full & ~(w_grant & w_byp);

  for (genvar s = 0; s < NR_SRC; s++) begin : g_src
    fu_wb_fifo #(
      .BUF_DEPTH(BUF_DEPTH),
      .T        (fu_output_t)
    ) u_fifo (
      .clk    (clk),
      .rstn   (rstn),
      .i_push (w_push[s]),
      .i_dat  (src_i[s]),
      .i_pop  (w_pop[s]),
      .o_full (w_full[s]),
      .o_empty(w_empty[s]),
      .o_head (w_head[s])
    );
  end

  // Scan from r_rr and hand the first NR_PORTS candidates to ports 0.. in scan order.
  always_comb begin
    w_grant    = '0;
    w_port_vld = '0;
    w_rr_nxt   = r_rr;
    w_sidx     = '0;
    w_nport    = 0;
    for (int p = 0; p < NR_PORTS; p++) w_port_dat[p] = r_wb[p];
    for (int k = 0; k < NR_SRC; k++) begin
      w_sidx = IDX_W'(rr_wrap(int'(r_rr) + k, NR_SRC));
      if (w_cand[w_sidx] && (w_nport < NR_PORTS)) begin
        w_grant[w_sidx] = 1'b1;
        for (int p = 0; p < NR_PORTS; p++) begin
          if (w_nport == p) begin
            w_port_vld[p] = 1'b1;
            w_port_dat[p] = w_empty[w_sidx] ? src_i[w_sidx] : w_head[w_sidx];
          end
        end
        w_rr_nxt = IDX_W'(rr_wrap(int'(w_sidx) + 1, NR_SRC));
        w_nport  = w_nport + 1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rr     <= '0;
      r_wb_vld <= '0;
      for (int p = 0; p < NR_PORTS; p++) r_wb[p] <= '0;
    end else begin
      r_rr     <= w_rr_nxt;
      r_wb_vld <= w_port_vld;
      for (int p = 0; p < NR_PORTS; p++) r_wb[p] <= w_port_dat[p];
    end
  end

  assign wb_valid_o = r_wb_vld;

  for (genvar p = 0; p < NR_PORTS; p++) begin : g_port
    assign wb_o[p]         = r_wb[p];
    assign completion_o[p] = '{id: r_wb[p].id, valid: r_wb_vld[p]};
  end
endmodule

// File: tb/tb_fu_wb_arbiter.sv
// Bench for fu_wb_arbiter: queue-level reference model compared every cycle, scoreboard, directed literals.
module tb_fu_wb_arbiter;
  import fu_wb_arbiter_pkg::*;

  localparam int NS  = 5;
  localparam int NP  = 2;
  localparam int BD  = 2;
  localparam int NP6 = 6;
`ifdef FU_WB_BYPASS_EN
  localparam int LAT = 1;
  localparam bit BYP = 1'b1;
`else
  localparam int LAT = 2;
  localparam bit BYP = 1'b0;
`endif

  logic             clk;
  logic             rstn;
  fu_output_t       src_i [NS];
  logic [NS-1:0]    src_valid_i;
  logic [NS-1:0]    src_ready_o;
  fu_output_t       wb_o [NP];
  logic [NP-1:0]    wb_valid_o;
  completion_port_t completion_o [NP];
  logic [NS-1:0]    src_ready6;
  fu_output_t       wb6 [NP6];
  logic [NP6-1:0]   wb_valid6;
  completion_port_t comp6 [NP6];

  int n_checks = 0;
  int n_errors = 0;
  int seq = 100;

  fu_wb_arbiter #(.NR_SRC(NS), .NR_PORTS(NP), .BUF_DEPTH(BD)) dut (
    .clk(clk), .rstn(rstn), .src_i(src_i), .src_valid_i(src_valid_i), .src_ready_o(src_ready_o),
    .wb_o(wb_o), .wb_valid_o(wb_valid_o), .completion_o(completion_o));

  fu_wb_arbiter #(.NR_SRC(NS), .NR_PORTS(NP6), .BUF_DEPTH(BD)) dut6 (
    .clk(clk), .rstn(rstn), .src_i(src_i), .src_valid_i(src_valid_i), .src_ready_o(src_ready6),
    .wb_o(wb6), .wb_valid_o(wb_valid6), .completion_o(comp6));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic fu_output_t mk(input int s, input int q);
    fu_output_t r;
    r.id   = TRANS_ID_BITS'(q);
    r.data = XLEN'(q);
    r.rd   = 5'(s);
    return r;
  endfunction

  task automatic drive(input logic [NS-1:0] m);
    for (int s = 0; s < NS; s++) begin
      src_i[s] = mk(s, seq);
      seq++;
    end
    src_valid_i = m;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: plain queues per source, a rotating start index, expected port contents.
  fu_output_t    m_q [NS][$];
  int            m_rr = 0;
  fu_output_t    exp_wb [NP];
  logic [NP-1:0] exp_vld = '0;
  logic [NS-1:0] exp_rdy = '1;
  bit            outstanding [int];

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int s = 0; s < NS; s++) m_q[s].delete();
      for (int p = 0; p < NP; p++) exp_wb[p] = '0;
      m_rr    = 0;
      exp_vld = '0;
      exp_rdy = '1;
      outstanding.delete();
    end else begin
      int            n;
      int            nrr;
      int            s;
      logic [NS-1:0] rdy;
      logic [NS-1:0] taken;
      for (int i = 0; i < NS; i++) rdy[i] = (m_q[i].size() < BD);
      taken   = '0;
      n       = 0;
      nrr     = m_rr;
      exp_vld = '0;
      for (int k = 0; k < NS; k++) begin
        s = (m_rr + k) % NS;
        if (n < NP && (m_q[s].size() > 0 || (BYP && src_valid_i[s]))) begin
          if (m_q[s].size() > 0) exp_wb[n] = m_q[s].pop_front();
          else begin
            exp_wb[n] = src_i[s];
            taken[s]  = 1'b1;
            outstanding[int'(src_i[s].data)] = 1'b1;
          end
          exp_vld[n] = 1'b1;
          n++;
          nrr = (s + 1) % NS;
        end
      end
      m_rr = nrr;
      for (int i = 0; i < NS; i++) begin
        if (src_valid_i[i] && rdy[i] && !taken[i]) begin
          m_q[i].push_back(src_i[i]);
          outstanding[int'(src_i[i].data)] = 1'b1;
        end
        exp_rdy[i] = (m_q[i].size() < BD);
      end
    end
  end

  always @(negedge clk) begin
    if (rstn === 1'b1) begin
      chk("wb_valid", 64'(wb_valid_o), 64'(exp_vld));
      chk("src_ready", 64'(src_ready_o), 64'(exp_rdy));
      for (int p = 0; p < NP; p++) begin
        chk("wb_payload", 64'(wb_o[p]), 64'(exp_wb[p]));
        chk("cpl_id", 64'(completion_o[p].id), 64'(exp_wb[p].id));
        chk("cpl_valid", 64'(completion_o[p].valid), 64'(exp_vld[p]));
        if (wb_valid_o[p]) begin
          n_checks++;
          if (!outstanding.exists(int'(wb_o[p].data))) begin
            n_errors++;
            $display("FAIL sb_unknown_or_dup: port %0d emitted data %0h, required an accepted, not yet emitted result", p, wb_o[p].data);
          end else outstanding.delete(int'(wb_o[p].data));
        end
      end
    end
  end

  logic [NS-1:0] t3_rdy [3] = '{5'b00011, 5'b01100, 5'b10001};
  int            t3_rd0 [3] = '{0, 2, 4};
  int            t3_rd1 [3] = '{1, 3, 0};

  initial begin
    src_valid_i = '0;
    for (int s = 0; s < NS; s++) src_i[s] = '0;
    for (int p = 0; p < NP; p++) exp_wb[p] = '0;
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;

    chk("reset_wb_valid", 64'(wb_valid_o), 64'(0));
    chk("reset_wb_payload", 64'(wb_o[1]), 64'(0));
    for (int c = 0; c < 3; c++) begin
      step();
      chk("idle_ready", 64'(src_ready_o), 64'(5'b11111));
      chk("idle_wb_valid", 64'(wb_valid_o), 64'(0));
    end

    // Single result on source 0 with id 7.
    src_i[0]    = mk(0, 7);
    src_valid_i = 5'b00001;
    step();
    src_valid_i = '0;
    for (int c = 1; c <= 3; c++) begin
      chk("lat_wb_valid", 64'(wb_valid_o), (c == LAT) ? 64'(2'b01) : 64'(0));
      if (c == LAT) begin
        chk("lat_wb_id", 64'(wb_o[0].id), 64'(7));
        chk("lat_cpl_id", 64'(completion_o[0].id), 64'(7));
      end
      step();
    end

    rstn = 1'b0;
    #2 rstn = 1'b1;

    // All sources valid for 4 cycles: rotation, full-queue ready, and 6-port wrap.
    for (int c = 0; c < 4; c++) begin
      drive('1);
      step();
      if (c >= 1) begin
        chk("rot_wb_valid", 64'(wb_valid_o), 64'(2'b11));
        chk("rot_port0_src", 64'(wb_o[0].rd), 64'(t3_rd0[c-1]));
        chk("rot_port1_src", 64'(wb_o[1].rd), 64'(t3_rd1[c-1]));
        chk("full_ready", 64'(src_ready_o), 64'(t3_rdy[c-1]));
        chk("p6_wb_valid", 64'(wb_valid6), 64'(6'b011111));
        chk("p6_port0_src", 64'(wb6[0].rd), 64'(0));
        chk("p6_port4_src", 64'(wb6[4].rd), 64'(4));
      end
    end
    src_valid_i = '0;
    repeat (8) step();
    chk("burst_drained", 64'(outstanding.size()), 64'(0));

    // Random traffic with one reset in the middle of a saturated burst.
    for (int c = 0; c < 4000; c++) begin
      if (c == 2000) begin
        for (int k = 0; k < 3; k++) begin
          drive('1);
          step();
        end
        chk("pre_reset_busy", 64'(wb_valid_o), 64'(2'b11));
        rstn = 1'b0;
        #1;
        chk("midreset_wb_valid", 64'(wb_valid_o), 64'(0));
        chk("midreset_cpl_valid", 64'(completion_o[0].valid), 64'(0));
        rstn = 1'b1;
        #1;
        chk("postreset_ready", 64'(src_ready_o), 64'(5'b11111));
      end
      begin
        logic [NS-1:0] m;
        for (int s = 0; s < NS; s++) m[s] = ($urandom_range(0, 9) < 6);
        drive(m);
      end
      step();
    end
    src_valid_i = '0;
    repeat (10) step();
    chk("random_drained", 64'(outstanding.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
